// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the arithmetic ALU and its branch
//               condition consumer: opcodes, flag bit positions, condition
//               codes and the branch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Arithmetic opcodes, identical to the encoding used by the ALU itself
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;

  // Bit positions inside the 4-bit {C,V,S,Z} flag vector
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  // Branch condition codes; 4'hD..4'hF are reserved
  localparam logic [3:0] CC_AL = 4'h0;
  localparam logic [3:0] CC_EQ = 4'h1;
  localparam logic [3:0] CC_NE = 4'h2;
  localparam logic [3:0] CC_CS = 4'h3;
  localparam logic [3:0] CC_CC = 4'h4;
  localparam logic [3:0] CC_MI = 4'h5;
  localparam logic [3:0] CC_PL = 4'h6;
  localparam logic [3:0] CC_VS = 4'h7;
  localparam logic [3:0] CC_VC = 4'h8;
  localparam logic [3:0] CC_GE = 4'h9;
  localparam logic [3:0] CC_LT = 4'hA;
  localparam logic [3:0] CC_GT = 4'hB;
  localparam logic [3:0] CC_LE = 4'hC;

  // Branch resolution state machine
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } br_state_e;

  // Assemble a flag vector from its individual bits
  function automatic logic [3:0] make_flags(input logic c, input logic v,
                                            input logic s, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_S] = s;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cond_branch_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cond_branch_if
// Description : Bundle of ALU result/flag inputs, branch request handshake
//               and branch resolution handshake between the fetch side
//               (master) and the condition evaluator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cond_branch_if #(
  parameter int W  = 16,
  parameter int CW = 4
);

  // ALU side
  logic          alu_issue;
  logic [W-1:0]  alu_out;
  logic          alu_carry;
  logic          alu_overflow;
  logic          alu_sign;
  logic          flag_clr;

  // Branch request
  logic          br_valid;
  logic          br_ready;
  logic [CW-1:0] br_cond;
  logic [W-1:0]  br_target;

  // Branch resolution
  logic          res_valid;
  logic          res_ready;
  logic          res_taken;
  logic [W-1:0]  res_target;
  logic          res_illegal;

  // Architectural flags {C,V,S,Z}
  logic [3:0]    flags;

  modport master (
    output alu_issue, alu_out, alu_carry, alu_overflow, alu_sign, flag_clr,
    output br_valid, br_cond, br_target, res_ready,
    input  br_ready, res_valid, res_taken, res_target, res_illegal, flags
  );

  modport slave (
    input  alu_issue, alu_out, alu_carry, alu_overflow, alu_sign, flag_clr,
    input  br_valid, br_cond, br_target, res_ready,
    output br_ready, res_valid, res_taken, res_target, res_illegal, flags
  );

endinterface : alu_cond_branch_if
`default_nettype wire

// File: rtl/alu_cond_branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational branch condition evaluator. Maps a
//               condition code and a {C,V,S,Z} flag vector to a taken bit,
//               flagging reserved codes as illegal (never taken).
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import alu_pkg::*;
#(
  parameter int CW = 4
) (
  input  wire logic [3:0]    flags_i,
  input  wire logic [CW-1:0] cond_i,
  output logic               taken_o,
  output logic               illegal_o
);

  logic c_flag;
  logic v_flag;
  logic s_flag;
  logic z_flag;

  assign c_flag = flags_i[FLAG_C];
  assign v_flag = flags_i[FLAG_V];
  assign s_flag = flags_i[FLAG_S];
  assign z_flag = flags_i[FLAG_Z];

  // Decode the condition code against the flags; reserved codes fall through
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (cond_i)
      CW'(CC_AL): taken_o = 1'b1;
      CW'(CC_EQ): taken_o = z_flag;
      CW'(CC_NE): taken_o = ~z_flag;
      CW'(CC_CS): taken_o = c_flag;
      CW'(CC_CC): taken_o = ~c_flag;
      CW'(CC_MI): taken_o = s_flag;
      CW'(CC_PL): taken_o = ~s_flag;
      CW'(CC_VS): taken_o = v_flag;
      CW'(CC_VC): taken_o = ~v_flag;
      CW'(CC_GE): taken_o = (s_flag == v_flag);
      CW'(CC_LT): taken_o = (s_flag != v_flag);
      CW'(CC_GT): taken_o = ~z_flag & (s_flag == v_flag);
      CW'(CC_LE): taken_o = z_flag | (s_flag != v_flag);
      default: begin
        taken_o   = 1'b0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule : cond_eval
`default_nettype wire

// File: rtl/alu_cond_branch.sv
`default_nettype none
// ============================================================================
// Module      : alu_cond_branch
// Description : Consumer of the ALU result/flag outputs. Holds the
//               architectural {C,V,S,Z} register, forwards live ALU flags
//               in the cycle they arrive, and resolves branch conditions
//               over a valid/ready request/response handshake. Requests
//               stall while an issued op's flags are still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cond_branch
  import alu_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_cond_branch_if.slave bus
);

  // Flag tracking
  logic          issue_q;
  logic [3:0]    flags_q;
  logic [3:0]    flags_d;
  logic [3:0]    live_flags;
  logic [3:0]    src_flags;

  // Request/response control
  br_state_e     state_q;
  br_state_e     state_d;
  logic          pending;
  logic          br_ready;
  logic          accept;
  logic          eval_taken;
  logic          eval_illegal;

  // Response registers
  logic          res_valid_q;
  logic          res_valid_d;
  logic          res_taken_q;
  logic          res_taken_d;
  logic          res_illegal_q;
  logic          res_illegal_d;
  logic [W-1:0]  res_target_q;
  logic [W-1:0]  res_target_d;

  // The ALU's registered outputs are meaningful one cycle after issue; Z is
  // derived here because the ALU does not provide it. Carry is taken as-is.
  assign live_flags = make_flags(bus.alu_carry, bus.alu_overflow, bus.alu_sign,
                                 (bus.alu_out == '0));

  // Forward the arriving flags so a branch in the capture cycle sees them
  assign src_flags  = issue_q ? live_flags : flags_q;

  // An op issued this cycle has no result yet, so its flags are unknown
  assign pending    = bus.alu_issue;
  assign br_ready   = (state_q == ST_IDLE) & ~pending & ~rst;
  assign accept     = bus.br_valid & br_ready;

  cond_eval #(
    .CW (CW)
  ) u_cond_eval (
    .flags_i   (src_flags),
    .cond_i    (bus.br_cond),
    .taken_o   (eval_taken),
    .illegal_o (eval_illegal)
  );

  // Next flag value: a result capture takes priority over a clear request
  always_comb begin
    flags_d = flags_q;
    if (issue_q) begin
      flags_d = live_flags;
    end else if (bus.flag_clr) begin
      flags_d = 4'b0000;
    end
  end

  // Flag register and issue delay; reset discards any capture in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      issue_q <= bus.alu_issue;
      flags_q <= flags_d;
    end
  end

  // Next state and response contents: latch on accept, hold until drained
  always_comb begin
    state_d       = state_q;
    res_valid_d   = res_valid_q;
    res_taken_d   = res_taken_q;
    res_illegal_d = res_illegal_q;
    res_target_d  = res_target_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d       = ST_RESP;
          res_valid_d   = 1'b1;
          res_taken_d   = eval_taken;
          res_illegal_d = eval_illegal;
          res_target_d  = bus.br_target;
        end
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and response registers; reset drops any outstanding response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      res_target_q  <= '0;
    end else begin
      state_q       <= state_d;
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      res_illegal_q <= res_illegal_d;
      res_target_q  <= res_target_d;
    end
  end

  assign bus.br_ready    = br_ready;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_taken   = res_taken_q;
  assign bus.res_illegal = res_illegal_q;
  assign bus.res_target  = res_target_q;
  assign bus.flags       = flags_q;

endmodule : alu_cond_branch
`default_nettype wire

// File: tb/tb_alu_cond_branch.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cond_branch
// Description : Self-checking bench for alu_cond_branch: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cond_branch;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_cond_branch_if #(.W(16), .CW(4)) bif ();

  alu_cond_branch #(.W(16), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0]  m_flags;   // {C,V,S,Z}
  logic        m_iss_d;   // an op was issued on the previous cycle
  logic        m_rv;
  logic        m_rt;
  logic        m_ri;
  logic [15:0] m_rtgt;

  // Condition semantics, written from the condition table; {taken, illegal}
  function automatic logic [1:0] ref_eval(input logic [3:0] f, input logic [3:0] cc);
    logic c, v, s, z;
    c = f[3]; v = f[2]; s = f[1]; z = f[0];
    case (cc)
      4'h0: return 2'b10;
      4'h1: return {z, 1'b0};
      4'h2: return {!z, 1'b0};
      4'h3: return {c, 1'b0};
      4'h4: return {!c, 1'b0};
      4'h5: return {s, 1'b0};
      4'h6: return {!s, 1'b0};
      4'h7: return {v, 1'b0};
      4'h8: return {!v, 1'b0};
      4'h9: return {s == v, 1'b0};
      4'hA: return {s != v, 1'b0};
      4'hB: return {!z && (s == v), 1'b0};
      4'hC: return {z || (s != v), 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic exp_ready();
    return !m_rv && !bif.alu_issue && !rst;
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge
  task automatic tick();
    logic [3:0] live;
    logic [3:0] src;
    logic [1:0] r;
    logic       rdy;
    live = {bif.alu_carry, bif.alu_overflow, bif.alu_sign, (bif.alu_out == 16'h0)};
    src  = m_iss_d ? live : m_flags;
    rdy  = exp_ready();
    if (rst) begin
      m_flags = 4'h0; m_iss_d = 1'b0;
      m_rv = 1'b0; m_rt = 1'b0; m_ri = 1'b0; m_rtgt = 16'h0;
    end else begin
      if (m_rv) begin
        if (bif.res_ready) m_rv = 1'b0;
      end else if (bif.br_valid && rdy) begin
        r = ref_eval(src, bif.br_cond);
        m_rt = r[1]; m_ri = r[0]; m_rtgt = bif.br_target; m_rv = 1'b1;
      end
      if (m_iss_d) m_flags = live;
      else if (bif.flag_clr) m_flags = 4'h0;
      m_iss_d = bif.alu_issue;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [15:0] o, input logic c, input logic v, input logic s);
    bif.alu_out = o; bif.alu_carry = c; bif.alu_overflow = v; bif.alu_sign = s;
  endtask

  task automatic request(input logic [3:0] cc, input logic [15:0] tgt);
    bif.br_valid = 1'b1; bif.br_cond = cc; bif.br_target = tgt;
    tick();
    bif.br_valid = 1'b0;
  endtask

  task automatic release_resp();
    bif.res_ready = 1'b1;
    tick();
    bif.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.alu_issue = 1'b0; set_alu(16'h0, 1'b0, 1'b0, 1'b0); bif.flag_clr = 1'b0;
    bif.br_valid = 1'b0; bif.br_cond = 4'h0; bif.br_target = 16'h0; bif.res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bif.br_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b expected 0", bif.br_ready); end
    rst = 1'b0;
    tick();
    checks++;
    if (bif.flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", bif.flags); end
    checks++;
    if (bif.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bif.res_valid); end
    checks++;
    if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", bif.br_ready); end
    request(4'h0, 16'h0040);
    checks++;
    if (bif.res_valid !== 1'b1 || bif.res_taken !== 1'b1 || bif.res_target !== 16'h0040)
    begin errors++; $display("FAIL al_resp: got v=%b t=%b tgt=%h expected v=1 t=1 tgt=0040", bif.res_valid, bif.res_taken, bif.res_target); end
    release_resp();
    checks++;
    if (bif.res_valid !== 1'b0) begin errors++; $display("FAIL al_release: got %b expected 0", bif.res_valid); end
  endtask

  task automatic test_add_flags();
    bif.alu_issue = 1'b1;
    tick();
    bif.alu_issue = 1'b0;
    set_alu(16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    set_alu(16'h1234, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bif.flags !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b expected 1001", bif.flags); end
    request(4'h1, 16'h0100);
    checks++;
    if (bif.res_valid !== 1'b1 || bif.res_taken !== 1'b1) begin errors++; $display("FAIL eq_taken: got v=%b t=%b expected v=1 t=1", bif.res_valid, bif.res_taken); end
    release_resp();
    request(4'h2, 16'h0200);
    checks++;
    if (bif.res_valid !== 1'b1 || bif.res_taken !== 1'b0) begin errors++; $display("FAIL ne_taken: got v=%b t=%b expected v=1 t=0", bif.res_valid, bif.res_taken); end
    release_resp();
  endtask

  task automatic test_forward();
    bif.alu_issue = 1'b1;
    bif.br_valid = 1'b1; bif.br_cond = 4'hA; bif.br_target = 16'h1111;
    #1;
    checks++;
    if (bif.br_ready !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %b expected 0", bif.br_ready); end
    tick();
    bif.alu_issue = 1'b0;
    set_alu(16'h8000, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready: got %b expected 1", bif.br_ready); end
    tick();
    bif.br_valid = 1'b0;
    set_alu(16'h0001, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bif.res_valid !== 1'b1 || bif.res_taken !== 1'b0 || bif.res_target !== 16'h1111)
    begin errors++; $display("FAIL fwd_lt: got v=%b t=%b tgt=%h expected v=1 t=0 tgt=1111", bif.res_valid, bif.res_taken, bif.res_target); end
    checks++;
    if (bif.flags !== 4'b0110) begin errors++; $display("FAIL sub_flags: got %b expected 0110", bif.flags); end
    release_resp();
    request(4'h9, 16'h2222);
    checks++;
    if (bif.res_taken !== 1'b1) begin errors++; $display("FAIL ge_taken: got %b expected 1", bif.res_taken); end
    release_resp();
  endtask

  task automatic test_backpressure();
    bif.br_valid = 1'b1; bif.br_cond = 4'h5; bif.br_target = 16'hBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bif.res_valid !== 1'b1 || bif.res_taken !== 1'b1 || bif.res_target !== 16'hBEEF || bif.br_ready !== 1'b0)
      begin errors++; $display("FAIL hold_%0d: got v=%b t=%b tgt=%h rdy=%b expected v=1 t=1 tgt=beef rdy=0", i, bif.res_valid, bif.res_taken, bif.res_target, bif.br_ready); end
      tick();
    end
    bif.br_valid = 1'b0;
    release_resp();
    checks++;
    if (bif.res_valid !== 1'b0 || bif.br_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got v=%b rdy=%b expected v=0 rdy=1", bif.res_valid, bif.br_ready); end
  endtask

  task automatic test_illegal_and_clear();
    request(4'hE, 16'h3333);
    checks++;
    if (bif.res_taken !== 1'b0 || bif.res_illegal !== 1'b1) begin errors++; $display("FAIL illegal: got t=%b i=%b expected t=0 i=1", bif.res_taken, bif.res_illegal); end
    release_resp();
    bif.alu_issue = 1'b1;
    tick();
    bif.alu_issue = 1'b0;
    bif.flag_clr = 1'b1;
    set_alu(16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    bif.flag_clr = 1'b0;
    checks++;
    if (bif.flags !== 4'b1000) begin errors++; $display("FAIL capture_wins: got %b expected 1000", bif.flags); end
    bif.flag_clr = 1'b1;
    tick();
    bif.flag_clr = 1'b0;
    checks++;
    if (bif.flags !== 4'b0000) begin errors++; $display("FAIL flag_clr: got %b expected 0000", bif.flags); end
  endtask

  task automatic test_reset_mid_resp();
    set_alu(16'h0001, 1'b0, 1'b0, 1'b0);
    request(4'h0, 16'h4444);
    bif.alu_issue = 1'b1;
    tick();
    bif.alu_issue = 1'b0;
    set_alu(16'h0000, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bif.res_valid !== 1'b0 || bif.flags !== 4'h0) begin errors++; $display("FAIL rst_resp: got v=%b f=%b expected v=0 f=0000", bif.res_valid, bif.flags); end
    tick();
    checks++;
    if (bif.flags !== 4'h0) begin errors++; $display("FAIL rst_no_capture: got %b expected 0000", bif.flags); end
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 400; i++) begin
      bif.alu_issue = ($urandom_range(2) == 0);
      bif.alu_sign  = $urandom_range(1);
      bif.alu_carry = bif.alu_sign ? 1'b0 : 1'($urandom_range(1));
      bif.alu_overflow = $urandom_range(1);
      bif.alu_out   = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      bif.flag_clr  = ($urandom_range(7) == 0);
      bif.res_ready = $urandom_range(1);
      rst           = ($urandom_range(63) == 0);
      if (!bif.br_valid) begin
        bif.br_valid  = $urandom_range(1);
        bif.br_cond   = 4'($urandom);
        bif.br_target = 16'($urandom);
      end
      #1;
      checks++;
      if (bif.br_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, bif.br_ready, exp_ready()); end
      acc = bif.br_valid && exp_ready();
      tick();
      if (acc) bif.br_valid = 1'b0;
      checks++;
      if (bif.flags !== m_flags) begin errors++; $display("FAIL rnd_flags[%0d]: got %b expected %b", i, bif.flags, m_flags); end
      checks++;
      if (bif.res_valid !== m_rv) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bif.res_valid, m_rv); end
      if (m_rv) begin
        checks++;
        if (bif.res_taken !== m_rt || bif.res_illegal !== m_ri || bif.res_target !== m_rtgt)
        begin errors++; $display("FAIL rnd_resp[%0d]: got t=%b i=%b tgt=%h expected t=%b i=%b tgt=%h", i, bif.res_taken, bif.res_illegal, bif.res_target, m_rt, m_ri, m_rtgt); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_flags = 4'h0; m_iss_d = 1'b0; m_rv = 1'b0; m_rt = 1'b0; m_ri = 1'b0; m_rtgt = 16'h0;
    test_reset();
    test_add_flags();
    test_forward();
    test_backpressure();
    test_illegal_and_clear();
    test_reset_mid_resp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_cond_branch
`default_nettype wire
